vga_timing_ctrl: RTL and testbench

Sequencer for the 640x480 VGA pixel path: divides the system clock into a pixel tick, runs the horizontal and vertical counters, and decodes `hsync`, `vsync` and `vidon`. It drives the `hc`/`vc`/`vidon` inputs of the pattern generators, such as the striped test pattern and the game renderer. It also owns the display-mode register that selects which generator is shown, and accepts mode changes from the host only at the start of vertical blanking, so switching never tears a frame.

---
 rtl/vga_timing_ctrl.sv | 149 ++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// 640x480 VGA timing sequencer: pixel-tick divider, h/v counters, sync/video decode
// and a vblank-synchronised display-mode register. Define VGA_FRAME_CNT_EN to add frame_cnt.
module vga_timing_ctrl #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned HPIXELS = 800,
    parameter int unsigned VLINES  = 521,
    parameter int unsigned HSP     = 128,
    parameter int unsigned VSP     = 2,
    parameter int unsigned HBP     = 144,
    parameter int unsigned HFP     = 784,
    parameter int unsigned VBP     = 31,
    parameter int unsigned VFP     = 511
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       mode_req,
    input  logic [1:0] mode_in,
    output logic       mode_ack,
    output logic [1:0] mode,
    output logic       pix_tick,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       hsync,
    output logic       vsync,
    output logic       vidon,
`ifdef VGA_FRAME_CNT_EN
    output logic [7:0] frame_cnt,
`endif
    output logic       frame_start
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST = 10'(HPIXELS - 1);
    localparam logic [9:0]  V_LAST = 10'(VLINES - 1);
    // Upper bounds may equal 1024, so window compares are done one bit wider.
    localparam logic [10:0] H_SP = 11'(HSP);
    localparam logic [10:0] V_SP = 11'(VSP);
    localparam logic [10:0] H_BP = 11'(HBP);
    localparam logic [10:0] H_FP = 11'(HFP);
    localparam logic [10:0] V_BP = 11'(VBP);
    localparam logic [10:0] V_FP = 11'(VFP);
    localparam logic [9:0]  VB_LINE = 10'(VFP % VLINES);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hc_q, hc_d;
    logic [9:0]       vc_q, vc_d;
    logic             tick_q;
    logic             fs_q;
    logic             advance;
    logic             h_wrap;
    logic             frame_evt;
    logic             vblank_evt;
    state_e           state_q;
    logic [1:0]       mode_q;
    logic             ack_q;

    always_comb begin
        advance    = (div_q == DIV_LAST);
        h_wrap     = advance && (hc_q == H_LAST);
        div_d      = advance ? '0 : div_q + DIV_W'(1);
        hc_d       = hc_q;
        vc_d       = vc_q;
        if (advance) begin
            hc_d = h_wrap ? '0 : hc_q + 10'd1;
        end
        if (h_wrap) begin
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
        end
        frame_evt  = h_wrap && (vc_q == V_LAST);
        vblank_evt = h_wrap && (vc_d == VB_LINE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            div_q  <= '0;
            hc_q   <= '0;
            vc_q   <= '0;
            tick_q <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            hc_q   <= hc_d;
            vc_q   <= vc_d;
            tick_q <= advance;
            fs_q   <= frame_evt;
        end
    end

    // Acceptance is evaluated on the edge that moves the counters to hc=0, vc=VFP,
    // so the new mode and the ack appear together with that position.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mode_req) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!mode_req) begin
                        state_q <= ST_IDLE;
                    end else if (vblank_evt) begin
                        mode_q  <= mode_in;
                        ack_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fc_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            fc_q <= '0;
        end else if (frame_evt) begin
            fc_q <= fc_q + 8'd1;
        end
    end

    assign frame_cnt = fc_q;
`endif

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign pix_tick    = tick_q;
    assign frame_start = fs_q;
    assign mode        = mode_q;
    assign mode_ack    = ack_q;
    assign hsync       = ({1'b0, hc_q} >= H_SP);
    assign vsync       = ({1'b0, vc_q} >= V_SP);
    assign vidon       = ({1'b0, hc_q} >= H_BP) && ({1'b0, hc_q} < H_FP) &&
                         ({1'b0, vc_q} >= V_BP) && ({1'b0, vc_q} < V_FP);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on reduced timing: an arithmetic model derived from the
// clock count since reset is compared every cycle, plus directed literal checks.
module tb_vga_timing_ctrl;

    localparam int unsigned CD  = 2;
    localparam int unsigned HP  = 40;
    localparam int unsigned VL  = 30;
    localparam int unsigned HSP = 6;
    localparam int unsigned VSP = 2;
    localparam int unsigned HBP = 9;
    localparam int unsigned HFP = 35;
    localparam int unsigned VBP = 4;
    localparam int unsigned VFP = 26;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       mode_req = 1'b0;
    logic [1:0] mode_in = 2'd0;
    logic       mode_ack;
    logic [1:0] mode;
    logic       pix_tick;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       hsync;
    logic       vsync;
    logic       vidon;
    logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .CLK_DIV (CD),
        .HPIXELS (HP),
        .VLINES  (VL),
        .HSP     (HSP),
        .VSP     (VSP),
        .HBP     (HBP),
        .HFP     (HFP),
        .VBP     (VBP),
        .VFP     (VFP)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .mode_req    (mode_req),
        .mode_in     (mode_in),
        .mode_ack    (mode_ack),
        .mode        (mode),
        .pix_tick    (pix_tick),
        .hc          (hc),
        .vc          (vc),
        .hsync       (hsync),
        .vsync       (vsync),
        .vidon       (vidon),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt   (frame_cnt),
`endif
        .frame_start (frame_start)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Model: n = clock edges since reset released; everything else follows arithmetically.
    int         n = 0;
    int         run = 0;
    bit         m_valid = 1'b0;
    logic [1:0] m_mode = 2'd0;
    bit         m_ack = 1'b0;
    int         m_fc = 0;

    initial begin
        int k, h, v;
        bit tick, vb, acc;
        forever begin
            @(posedge clk);
            if (clr) begin
                n = 0; run = 0; m_mode = 2'd0; m_ack = 1'b0; m_fc = 0; m_valid = 1'b1;
            end else if (m_valid) begin
                n++;
                tick = (n % CD) == 0;
                k = n / CD;
                h = k % HP;
                v = (k / HP) % VL;
                vb = tick && h == 0 && v == VFP;
                acc = mode_req && run >= 1 && vb;
                if (acc) m_mode = mode_in;
                m_ack = acc;
                run = acc ? 0 : (mode_req ? run + 1 : 0);
                if (tick && h == 0 && v == 0) m_fc = (m_fc + 1) % 256;
            end
            @(negedge clk);
            if (m_valid) begin
                k = n / CD;
                h = k % HP;
                v = (k / HP) % VL;
                tick = (n > 0) && (n % CD == 0);
                check("hc", hc, h);
                check("vc", vc, v);
                check("pix_tick", pix_tick, tick);
                check("hsync", hsync, !(h < HSP));
                check("vsync", vsync, !(v < VSP));
                check("vidon", vidon, (h >= HBP && h < HFP && v >= VBP && v < VFP));
                check("frame_start", frame_start, (tick && h == 0 && v == 0));
                check("mode", mode, m_mode);
                check("mode_ack", mode_ack, m_ack);
`ifdef VGA_FRAME_CNT_EN
                check("frame_cnt", frame_cnt, m_fc);
`endif
            end
        end
    end

    task automatic wait_at(input int h, input int v, input int limit);
        bit hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk);
            hit = (hc == 10'(h)) && (vc == 10'(v));
        end
        if (!hit) timeout_fail("wait_at");
    endtask

    task automatic request(input logic [1:0] m, input int dur, input bit must_ack);
        bit got = 1'b0;
        mode_in  = m;
        mode_req = 1'b1;
        for (int i = 0; i < dur && !got; i++) begin
            @(negedge clk);
            got = mode_ack;
        end
        mode_req = 1'b0;
        if (must_ack && !got) timeout_fail("request_ack");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, lo, tk;
        bit hit;

        // Reset state
        clr = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_hc", hc, 0);
        check("rst_vc", vc, 0);
        check("rst_hsync", hsync, 0);
        check("rst_vsync", vsync, 0);
        check("rst_vidon", vidon, 0);
        check("rst_mode", mode, 0);
        check("rst_ack", mode_ack, 0);
        check("rst_tick", pix_tick, 0);
        check("rst_fs", frame_start, 0);
        clr = 1'b0;

        // First tick latency
        cnt = 0; hit = 1'b0;
        while (cnt < 10 && !hit) begin
            @(negedge clk);
            cnt++;
            hit = pix_tick;
        end
        check("first_tick_latency", cnt, 2);
        check("first_tick_hc", hc, 1);

        // Frame period
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk);
            hit = frame_start;
        end
        if (!hit) timeout_fail("frame_start_first");
        cnt = 0; hit = 1'b0;
        while (cnt < 3000 && !hit) begin
            @(negedge clk);
            cnt++;
            hit = frame_start;
        end
        check("frame_period", cnt, 2400);

        // hsync width over one line
        wait_at(0, 5, 3000);
        lo = 0; tk = 0;
        for (int i = 0; i < 80; i++) begin
            if (i > 0) @(negedge clk);
            if (pix_tick) tk++;
            if (pix_tick && !hsync) lo++;
        end
        check("line_ticks", tk, 40);
        check("hsync_low_ticks", lo, 6);

        // vsync width over one frame
        wait_at(0, 0, 3000);
        lo = 0;
        for (int i = 0; i < 2400; i++) begin
            if (i > 0) @(negedge clk);
            if (pix_tick && hc == 10'd0 && !vsync) lo++;
        end
        check("vsync_low_lines", lo, 2);

        // Visible window edges
        wait_at(8, 4, 3000);
        check("vidon_before_hbp", vidon, 0);
        repeat (2) @(negedge clk);
        check("vidon_at_hbp_hc", hc, 9);
        check("vidon_at_hbp", vidon, 1);
        wait_at(34, 4, 200);
        check("vidon_last", vidon, 1);
        repeat (2) @(negedge clk);
        check("vidon_at_hfp_hc", hc, 35);
        check("vidon_at_hfp", vidon, 0);

        // Mode change mid-frame
        wait_at(0, 10, 3000);
        mode_in  = 2'd2;
        mode_req = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 2600 && !hit; i++) begin
            @(negedge clk);
            hit = mode_ack;
        end
        mode_req = 1'b0;
        if (!hit) timeout_fail("mode_change_ack");
        check("ack_hc", hc, 0);
        check("ack_vc", vc, 26);
        check("ack_mode", mode, 2);
        @(negedge clk);
        check("ack_single", mode_ack, 0);

        // Withdrawn request
        wait_at(0, 5, 3000);
        mode_in  = 2'd1;
        mode_req = 1'b1;
        wait_at(0, 15, 3000);
        mode_req = 1'b0;
        wait_at(0, 28, 3000);
        check("withdraw_mode", mode, 2);

        // Reset with a request pending
        wait_at(20, 12, 3000);
        mode_in  = 2'd3;
        mode_req = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        mode_req = 1'b0;
        check("midrst_hc", hc, 0);
        check("midrst_vc", vc, 0);
        check("midrst_mode", mode, 0);
        check("midrst_ack", mode_ack, 0);
        repeat (2) @(negedge clk);
        check("midrst_resume_hc", hc, 1);

        // Randomized traffic
        for (int it = 0; it < 15; it++) begin
            case ($urandom_range(0, 3))
                0: request(2'($urandom_range(0, 3)), 2600, 1'b1);
                1: request(2'($urandom_range(0, 3)), int'($urandom_range(1, 1500)), 1'b0);
                2: repeat ($urandom_range(1, 1000)) @(negedge clk);
                default: begin
                    repeat ($urandom_range(1, 800)) @(negedge clk);
                    clr = 1'b1;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    clr = 1'b0;
                end
            endcase
        end
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
